// File: rtl/pic_inta_sequencer.sv
// CPU-side responder of the 8259 interrupt path: raises INT, runs the two-pulse
// INTA handshake, maintains the In-Service Register and drives the vector byte.
module pic_inta_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irr_valid,
    input  logic [2:0] chosen_interrupt,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] irr_clear,
    output logic [7:0] isr
);

    typedef enum logic [2:0] {
        StIdle,
        StIntPend,
        StAck1,
        StWait2,
        StAck2
    } state_e;

    state_e     state;
    logic [2:0] level;
    logic       spurious;
    logic       inta_prev;

    logic       inta_fall;
    logic       inta_rise;
    logic       isr_any;
    logic [2:0] isr_lowest;
    logic       qualifies;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;

    assign inta_fall = inta_prev && !inta_n;
    assign inta_rise = !inta_prev && inta_n;
    assign isr_any   = |isr;

    // Lowest-indexed in-service level, i.e. the highest priority currently being served.
    always_comb begin
        isr_lowest = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (isr[i]) begin
                isr_lowest = 3'(i);
            end
        end
    end

    // Fully nested: only a strictly higher priority than anything in service may interrupt.
    assign qualifies = irr_valid && (!isr_any || (chosen_interrupt < isr_lowest));

    // ISR set/clear masks for this cycle; sets are OR-ed in after clears so a set wins.
    always_comb begin
        isr_set = 8'h00;
        isr_clr = 8'h00;
        if (eoi_valid) begin
            if (eoi_specific) begin
                isr_clr[eoi_level] = 1'b1;
            end else if (isr_any) begin
                isr_clr[isr_lowest] = 1'b1;
            end
        end
        if ((state == StAck2) && inta_rise && aeoi && !spurious) begin
            isr_clr[level] = 1'b1;
        end
        if ((state == StIntPend) && inta_fall && qualifies) begin
            isr_set[chosen_interrupt] = 1'b1;
        end
    end

    // Handshake FSM with registered outputs and ISR update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            level     <= 3'd0;
            spurious  <= 1'b0;
            inta_prev <= 1'b1;
            int_out   <= 1'b0;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            irr_clear <= 8'h00;
            isr       <= 8'h00;
        end else begin
            inta_prev <= inta_n;
            irr_clear <= 8'h00;
            isr       <= (isr & ~isr_clr) | isr_set;
            unique case (state)
                StIdle: begin
                    if (qualifies) begin
                        int_out <= 1'b1;
                        state   <= StIntPend;
                    end
                end
                StIntPend: begin
                    if (inta_fall) begin
                        int_out <= 1'b0;
                        state   <= StAck1;
                        if (qualifies) begin
                            level     <= chosen_interrupt;
                            spurious  <= 1'b0;
                            irr_clear <= 8'h01 << chosen_interrupt;
                        end else begin
                            level    <= SPURIOUS_LEVEL;
                            spurious <= 1'b1;
                        end
                    end
                end
                StAck1: begin
                    if (inta_rise) begin
                        state <= StWait2;
                    end
                end
                StWait2: begin
                    if (inta_fall) begin
                        data_oe  <= 1'b1;
                        data_out <= {vector_base, level};
                        state    <= StAck2;
                    end
                end
                StAck2: begin
                    if (inta_rise) begin
                        data_oe  <= 1'b0;
                        data_out <= 8'h00;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: a per-cycle vector table plus hand-written
// sequences for AEOI, EOI, reset mid-handshake and set/clear collision.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       irr_valid;
    logic [2:0] chosen_interrupt;
    logic [4:0] vector_base;
    logic       aeoi;
    logic       inta_n;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] irr_clear;
    logic [7:0] isr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pic_inta_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .irr_valid        (irr_valid),
        .chosen_interrupt (chosen_interrupt),
        .vector_base      (vector_base),
        .aeoi             (aeoi),
        .inta_n           (inta_n),
        .eoi_valid        (eoi_valid),
        .eoi_specific     (eoi_specific),
        .eoi_level        (eoi_level),
        .int_out          (int_out),
        .data_out         (data_out),
        .data_oe          (data_oe),
        .irr_clear        (irr_clear),
        .isr              (isr)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [2:0] ch;
        logic       inta;
        logic       eov;
        logic       eos;
        logic [2:0] eol;
        logic       io;
        logic       oe;
        logic [7:0] dout;
        logic [7:0] clr;
        logic [7:0] isr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic iv, input logic [2:0] ch, input logic inta,
                       input logic eov, input logic eos, input logic [2:0] eol,
                       input logic io, input logic oe, input logic [7:0] dout,
                       input logic [7:0] clr, input logic [7:0] isr_e);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ch = ch; v.inta = inta;
        v.eov = eov; v.eos = eos; v.eol = eol;
        v.io = io; v.oe = oe; v.dout = dout; v.clr = clr; v.isr = isr_e;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Full two-pulse acknowledge of one level, checking the visible milestones.
    task automatic do_ack(input logic [2:0] lvl, input logic [7:0] isr_set_e,
                          input logic [7:0] isr_end_e, input string tag);
        irr_valid = 1'b1; chosen_interrupt = lvl;
        tick();
        chk({tag, " int_out"}, {7'd0, int_out}, 8'h01);
        inta_n = 1'b0;
        tick();
        chk({tag, " isr set"}, isr, isr_set_e);
        chk({tag, " irr_clear"}, irr_clear, 8'h01 << lvl);
        irr_valid = 1'b0; inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        chk({tag, " data_oe"}, {7'd0, data_oe}, 8'h01);
        chk({tag, " vector"}, data_out, {vector_base, lvl});
        inta_n = 1'b1;
        tick();
        chk({tag, " data_oe off"}, {7'd0, data_oe}, 8'h00);
        chk({tag, " isr end"}, isr, isr_end_e);
    endtask

    initial begin
        reset = 1'b1; irr_valid = 1'b0; chosen_interrupt = 3'd0; vector_base = 5'b01000;
        aeoi = 1'b0; inta_n = 1'b1; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;

        //   rst iv ch   inta eov eos eol   io oe dout   clr    isr
        add(1, 0, 3'd0, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h00); // reset state
        // Basic acknowledge of level 5
        add(0, 1, 3'd5, 1, 0, 0, 3'd0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(0, 1, 3'd5, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h20, 8'h20);
        add(0, 0, 3'd5, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h20);
        add(0, 0, 3'd5, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h20);
        add(0, 0, 3'd5, 0, 0, 0, 3'd0,  0, 1, 8'h45, 8'h00, 8'h20);
        add(0, 0, 3'd5, 0, 0, 0, 3'd0,  0, 1, 8'h45, 8'h00, 8'h20);
        add(0, 0, 3'd5, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h20);
        add(0, 0, 3'd0, 1, 1, 1, 3'd5,  0, 0, 8'h00, 8'h00, 8'h00); // specific EOI 5
        // Put level 3 in service
        add(0, 1, 3'd3, 1, 0, 0, 3'd0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(0, 1, 3'd3, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h08, 8'h08);
        add(0, 0, 3'd3, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h08);
        add(0, 0, 3'd3, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h08);
        add(0, 0, 3'd3, 0, 0, 0, 3'd0,  0, 1, 8'h43, 8'h00, 8'h08);
        add(0, 0, 3'd3, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h08);
        // Lower priority blocked, higher priority nests
        add(0, 1, 3'd4, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h08);
        add(0, 1, 3'd3, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h08);
        add(0, 1, 3'd1, 1, 0, 0, 3'd0,  1, 0, 8'h00, 8'h00, 8'h08);
        add(0, 1, 3'd1, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h02, 8'h0A);
        add(0, 0, 3'd1, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);
        add(0, 0, 3'd1, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);
        add(0, 0, 3'd1, 0, 0, 0, 3'd0,  0, 1, 8'h41, 8'h00, 8'h0A);
        add(0, 0, 3'd1, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);
        // Spurious: request vanishes before first INTA
        add(0, 1, 3'd0, 1, 0, 0, 3'd0,  1, 0, 8'h00, 8'h00, 8'h0A);
        add(0, 0, 3'd0, 1, 0, 0, 3'd0,  1, 0, 8'h00, 8'h00, 8'h0A);
        add(0, 0, 3'd0, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);
        add(0, 0, 3'd0, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);
        add(0, 0, 3'd0, 0, 0, 0, 3'd0,  0, 1, 8'h47, 8'h00, 8'h0A);
        add(0, 0, 3'd0, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);
        // INTA fall in IDLE is ignored
        add(0, 0, 3'd0, 0, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);
        add(0, 0, 3'd0, 1, 0, 0, 3'd0,  0, 0, 8'h00, 8'h00, 8'h0A);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; irr_valid = vecs[i].iv; chosen_interrupt = vecs[i].ch;
            inta_n = vecs[i].inta; eoi_valid = vecs[i].eov; eoi_specific = vecs[i].eos;
            eoi_level = vecs[i].eol;
            tick();
            chk($sformatf("row%0d int_out", i), {7'd0, int_out}, {7'd0, vecs[i].io});
            chk($sformatf("row%0d data_oe", i), {7'd0, data_oe}, {7'd0, vecs[i].oe});
            chk($sformatf("row%0d data_out", i), data_out, vecs[i].dout);
            chk($sformatf("row%0d irr_clear", i), irr_clear, vecs[i].clr);
            chk($sformatf("row%0d isr", i), isr, vecs[i].isr);
        end
        eoi_valid = 1'b0; irr_valid = 1'b0; inta_n = 1'b1;

        // Clear levels 1 and 3, then AEOI acknowledge of level 2
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd1;
        tick();
        eoi_level = 3'd3;
        tick();
        eoi_valid = 1'b0;
        chk("eoi cleanup isr", isr, 8'h00);
        aeoi = 1'b1;
        do_ack(3'd2, 8'h04, 8'h00, "aeoi l2");
        aeoi = 1'b0;
        do_ack(3'd3, 8'h08, 8'h08, "ack l3");
        do_ack(3'd1, 8'h0A, 8'h0A, "ack l1");
        eoi_valid = 1'b1; eoi_specific = 1'b0;
        tick();
        chk("nonspecific eoi", isr, 8'h08);
        eoi_specific = 1'b1; eoi_level = 3'd3;
        tick();
        chk("specific eoi 3", isr, 8'h00);
        eoi_specific = 1'b0;
        tick();
        chk("nonspecific eoi empty", isr, 8'h00);
        eoi_valid = 1'b0;

        // Reset while driving the vector in ACK2
        irr_valid = 1'b1; chosen_interrupt = 3'd4;
        tick();
        inta_n = 1'b0;
        tick();
        irr_valid = 1'b0; inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        chk("pre-reset data_oe", {7'd0, data_oe}, 8'h01);
        reset = 1'b1;
        tick();
        chk("reset data_oe", {7'd0, data_oe}, 8'h00);
        chk("reset data_out", data_out, 8'h00);
        chk("reset isr", isr, 8'h00);
        chk("reset int_out", {7'd0, int_out}, 8'h00);
        reset = 1'b0; inta_n = 1'b1;
        tick();
        do_ack(3'd6, 8'h40, 8'h40, "post-reset l6");
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd6;
        tick();
        eoi_valid = 1'b0;
        chk("clear l6", isr, 8'h00);

        // Specific EOI for level 6 collides with its set on the first INTA
        irr_valid = 1'b1; chosen_interrupt = 3'd6;
        tick();
        inta_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd6;
        tick();
        eoi_valid = 1'b0;
        chk("collision isr", isr, 8'h40);
        chk("collision irr_clear", irr_clear, 8'h40);
        irr_valid = 1'b0; inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        chk("collision vector", data_out, 8'h46);
        inta_n = 1'b1;
        tick();
        chk("collision isr end", isr, 8'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
CPU-side responder of the 8259 PIC interrupt path. Consumes the Priority_Resolver result (IRR valid + chosen_interrupt) and raises INT to the CPU. Runs the two-pulse 8086-style INTA acknowledge handshake, maintains the In-Service Register (ISR), returns the interrupt vector on the data bus, and processes EOI commands. Sits between Priority_Resolver/IRR logic and the data bus buffer.

Parameters:
SPURIOUS_LEVEL, 3'd7, level reported when a request vanishes before the first INTA; ISR is not set for it.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
irr_valid  in  1  at least one unmasked IRR bit set (from resolver side)
chosen_interrupt  in  3  highest-priority pending level from Priority_Resolver
vector_base  in  5  ICW2 T7..T3
aeoi  in  1  automatic EOI mode enable
inta_n  in  1  CPU interrupt acknowledge, active low, synchronous to clk
eoi_valid  in  1  one-cycle EOI command strobe
eoi_specific  in  1  1 = specific EOI, 0 = non-specific
eoi_level  in  3  level for specific EOI
int_out  out  1  interrupt request to CPU
data_out  out  8  vector byte
data_oe  out  1  data bus drive enable
irr_clear  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
isr  out  8  In-Service Register

Behaviour:
- Reset (sync, active-high): state=IDLE, int_out=0, data_oe=0, data_out=0, irr_clear=0, isr=0, inta_prev=1. Reset mid-handshake aborts immediately; data_oe is low after that edge.
- Priority: fully nested; level 0 highest. A request qualifies when irr_valid && (isr==0 || chosen_interrupt < index of lowest set ISR bit). Equal or lower priority than in-service is blocked.
- INTA edges: fall = inta_prev && !inta_n; rise = !inta_prev && inta_n; inta_prev is registered every cycle.
- IDLE: qualifying request -> INT_PEND; int_out=1 from the next cycle (1-cycle latency).
- INT_PEND: int_out stays 1 even if the request drops. On fall:
  - Latch level. If the request still qualifies, level=chosen_interrupt, set isr[level], and pulse irr_clear[level] for exactly 1 cycle.
  - Otherwise, level=SPURIOUS_LEVEL, flag spurious, no ISR/IRR change.
  - int_out=0. Go to ACK1.
  - data_oe stays 0 during the first pulse.
- ACK1: wait for rise -> WAIT2.
- WAIT2: on fall -> ACK2, data_oe=1, data_out={vector_base, level}, registered and valid the cycle after the fall.
- ACK2: hold data while inta_n is low. On rise: data_oe=0, data_out=0; if aeoi && !spurious clear isr[level]. Go to IDLE.
- A new request is re-evaluated in IDLE only, the cycle after return.
- EOI (accepted in any state): non-specific clears the lowest-indexed set ISR bit (none set: no-op); specific clears isr[eoi_level].
- Simultaneous set and clear: all clears (EOI, AEOI) and sets are applied in the same cycle. If a set and a clear hit the same bit, the set wins.
- inta_n glitch-free and synchronous by contract. A fall in IDLE is ignored (no data drive).
- vector_base is sampled at the WAIT2 fall.

Test Plan:
1. Reset, vector_base=5'b01000, chosen=5, irr_valid=1 -> int_out=1 one cycle later. INTA pulse 1 -> irr_clear=8'h20 for 1 cycle, isr=8'h20, int_out=0. INTA pulse 2 -> data_oe=1, data_out=8'h45. Rise -> data_oe=0.
2. isr=8'h08 (level 3 in service): chosen=4 -> int_out stays 0; chosen=1 -> int_out=1. Full acknowledge -> isr=8'h0A, vector low bits=1.
3. Spurious: request raised, then irr_valid=0 before first INTA -> vector {base,3'd7}, isr unchanged, irr_clear all zero.
4. aeoi=1, acknowledge level 2 -> isr bit 2 set after pulse 1 and clear on pulse-2 rise. Then, with isr=8'h0A, non-specific EOI -> isr=8'h08; specific EOI level 3 -> isr=8'h00.
5. Reset asserted in ACK2 with data_oe=1 -> next cycle data_oe=0, isr=0, state IDLE. A subsequent request completes normally.
6. Specific EOI for level 6 in the same cycle the first INTA sets level 6 -> isr[6]=1 (set wins).
